// File: rtl/sf_pkg.sv
// Shared definitions for the softmax gradient collector.
//   Q15_ONE   : 1.0 in the softmax sign-magnitude gradient format (15 fraction bits)
//   SIGN_BIT  : position of the sign bit in a gradient word
//   state_t   : collector control states
//   sm_word_t : sign-magnitude gradient word view
package sf_pkg;

  localparam logic [31:0] Q15_ONE  = 32'h0000_8000;
  localparam int          SIGN_BIT = 31;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [30:0] mag;
  } sm_word_t;

endpackage

// File: rtl/softmax_grad_collector_if.sv
// Gradient stream interface (valid/ready) between the collector and the
// upstream weight-update logic.
//   grad_valid / grad_ready : beat handshake
//   grad_data               : sign-magnitude gradient word
//   grad_idx                : class index of grad_data
//   grad_last               : marks the final class of a readout
// master = collector side, slave = consumer side.
interface softmax_grad_collector_if #(
  parameter int DATA_W    = 32,
  parameter int IDX_WIDTH = 4
) ();

  logic                 grad_valid;
  logic                 grad_ready;
  logic [DATA_W-1:0]    grad_data;
  logic [IDX_WIDTH-1:0] grad_idx;
  logic                 grad_last;

  modport master (
    output grad_valid,
    output grad_data,
    output grad_idx,
    output grad_last,
    input  grad_ready
  );

  modport slave (
    input  grad_valid,
    input  grad_data,
    input  grad_idx,
    input  grad_last,
    output grad_ready
  );

endinterface

// File: rtl/sf_grad_scale.sv
// Combinational sign-magnitude right shift used for learning-rate scaling.
//   word_in  : sign-magnitude gradient word
//   shift    : logical right-shift applied to the magnitude
//   word_out : scaled word; a magnitude that shifts to zero gets a positive
//              sign so negative zero never leaves the block
module sf_grad_scale
  import sf_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [3:0]  shift,
  output logic [31:0] word_out
);

  logic [30:0] mag;

  assign mag      = word_in[30:0] >> shift;
  assign word_out = {(mag != '0) & word_in[SIGN_BIT], mag};

endmodule

// File: rtl/softmax_grad_collector.sv
// Softmax backprop gradient collector.
// Drives the softmax backprop readout, captures WIDTH gradient words (one per
// cycle) into a local buffer, then streams them out over a valid/ready
// interface.
//   clk, rst          : clock, asynchronous active-high reset
//   bp_req            : backprop request (pulse or level), remembered in pend
//   sf_out_ready      : softmax forward result valid (gates the start)
//   sf_out_data/idx   : softmax readout word and its index
//   sf_start          : start/advance strobe to the softmax
//   sf_backprop_ctrl  : backprop mode select, mirrors sf_start
//   grad (master)     : gradient stream
//   busy              : state != IDLE
//   err               : sticky index-mismatch flag
//   lr_shift          : gradient right shift, used only with SF_GRAD_SCALE_EN
// Build option: define SF_GRAD_SCALE_EN to scale outgoing magnitudes by lr_shift.
module softmax_grad_collector
  import sf_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int IDX_WIDTH = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bp_req,
  input  logic                 sf_out_ready,
  input  logic [DATA_W-1:0]    sf_out_data,
  input  logic [IDX_WIDTH-1:0] sf_out_idx,
  output logic                 sf_start,
  output logic                 sf_backprop_ctrl,
  softmax_grad_collector_if.master grad,
  output logic                 busy,
  output logic                 err,
  input  logic [3:0]           lr_shift
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [IDX_WIDTH-1:0] cnt;
  logic                 pend;
  logic [DATA_W-1:0]    gbuf [WIDTH];

  logic                 idx_ok, cnt_last, accept, xfer;
  logic                 load_en;
  logic [IDX_WIDTH-1:0] load_idx;
  logic [DATA_W-1:0]    beat_raw, beat_word;

  assign idx_ok   = (sf_out_idx == cnt);
  assign cnt_last = (cnt == LAST_IDX);
  assign accept   = (state == IDLE) && pend && sf_out_ready;
  assign xfer     = grad.grad_valid && grad.grad_ready;

  // The first beat is loaded on the same edge that leaves CAPTURE so the
  // stream starts without a bubble; later beats load on each non-final transfer.
  assign load_idx = (state == CAPTURE) ? '0 : cnt + 1'b1;
  assign load_en  = ((state == CAPTURE) && idx_ok && cnt_last) ||
                    ((state == STREAM) && xfer && !grad.grad_last);
  assign beat_raw = gbuf[load_idx];

`ifdef SF_GRAD_SCALE_EN
  sf_grad_scale u_scale (
    .word_in  (beat_raw),
    .shift    (lr_shift),
    .word_out (beat_word)
  );
`else
  logic unused_lr_shift;
  assign unused_lr_shift = ^lr_shift;
  assign beat_word       = beat_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pend && sf_out_ready) state_nxt = CAPTURE;
      CAPTURE: begin
        if (!idx_ok)       state_nxt = IDLE;
        else if (cnt_last) state_nxt = STREAM;
      end
      STREAM:  if (xfer && grad.grad_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The strobe in CAPTURE also advances the softmax; on a mismatch it is
  // withheld so the softmax is left where it stopped.
  always_comb begin
    sf_start = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:    sf_start = pend && sf_out_ready;
      CAPTURE: sf_start = idx_ok;
      default: sf_start = 1'b0;
    endcase
    sf_backprop_ctrl = sf_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      // A new request outranks consumption so nothing arriving at accept is lost.
      if (bp_req)      pend <= 1'b1;
      else if (accept) pend <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            err <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!idx_ok)       err <= 1'b1;
          else if (cnt_last) cnt <= '0;
          else               cnt <= cnt + 1'b1;
        end
        STREAM: begin
          if (xfer && !grad.grad_last) cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == CAPTURE) && idx_ok) gbuf[cnt] <= sf_out_data;
  end

  // ---- stream output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grad.grad_valid <= 1'b0;
      grad.grad_data  <= '0;
      grad.grad_idx   <= '0;
      grad.grad_last  <= 1'b0;
    end else if (load_en) begin
      grad.grad_valid <= 1'b1;
      grad.grad_data  <= beat_word;
      grad.grad_idx   <= load_idx;
      grad.grad_last  <= (load_idx == LAST_IDX);
    end else if (xfer && grad.grad_last) begin
      grad.grad_valid <= 1'b0;
    end
  end

endmodule
